// File: rtl/cic_decimator_cfg.sv
// Runtime-rate CIC decimator for a 1-bit PDM stream: input-rate integrators, a time-multiplexed comb, and a valid/ready output.
// Optional build macro CIC_ROUND_EN selects round-half-up with saturation instead of plain truncation.
module cic_decimator_cfg #(
    parameter int ORDER      = 4,
    parameter int RATE_W     = 8,
    parameter int DIFF_DELAY = 1,
    parameter int ACC_WIDTH  = ORDER * RATE_W + 2,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_pdm_in,
    input  logic                 i_in_valid,
    input  logic [RATE_W-1:0]    i_rate_cfg,
    output logic [OUT_WIDTH-1:0] o_out_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_overrun
);

    localparam int SHIFT = ACC_WIDTH - OUT_WIDTH;
    localparam int STG_W = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [RATE_W-1:0] MIN_RATE = RATE_W'(ORDER + 2);
    localparam logic [STG_W-1:0]  LAST_STG = STG_W'(ORDER - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COMB = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic signed [ACC_WIDTH-1:0] r_int      [ORDER];
    logic signed [ACC_WIDTH-1:0] w_int_next [ORDER];
    logic signed [ACC_WIDTH-1:0] r_dly      [ORDER][DIFF_DELAY];
    logic signed [ACC_WIDTH-1:0] r_comb_x;
    logic [RATE_W-1:0]           r_cnt;
    logic [RATE_W-1:0]           r_rate;
    logic [RATE_W-1:0]           w_rate_clamp;
    logic [RATE_W-1:0]           w_frame_rate;
    logic                        w_capture;
    logic [1:0]                  r_state;
    logic [STG_W-1:0]            r_stage;
    logic [OUT_WIDTH-1:0]        w_out_next;

    // Integrator next values; stage k adds the previous (registered) value of stage k-1, wrapping freely.
    always_comb begin
        w_int_next[0] = r_int[0] + (i_pdm_in ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}});
        for (int k = 1; k < ORDER; k++) begin
            w_int_next[k] = r_int[k] + r_int[k-1];
        end
    end

    // Frame ratio: a fresh clamped rate_cfg applies on the first input of a frame, the latched one afterwards.
    always_comb begin
        w_rate_clamp = (i_rate_cfg < MIN_RATE) ? MIN_RATE : i_rate_cfg;
        w_frame_rate = (r_cnt == RATE_W'(0)) ? w_rate_clamp : r_rate;
        w_capture    = i_in_valid && (r_cnt == (w_frame_rate - RATE_W'(1)));
    end

    // Integrator chain, input counter and per-frame rate latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k] <= '0;
            end
            r_cnt  <= RATE_W'(0);
            r_rate <= MIN_RATE;
        end else if (i_in_valid) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k] <= w_int_next[k];
            end
            if (r_cnt == RATE_W'(0)) begin
                r_rate <= w_rate_clamp;
            end
            r_cnt <= w_capture ? RATE_W'(0) : (r_cnt + RATE_W'(1));
        end
    end

    // Comb sequencer: one differentiator stage per cycle on a shared subtractor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_stage  <= '0;
            r_comb_x <= '0;
            for (int s = 0; s < ORDER; s++) begin
                for (int m = 0; m < DIFF_DELAY; m++) begin
                    r_dly[s][m] <= '0;
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_comb_x <= w_int_next[ORDER-1];
                        r_stage  <= '0;
                        r_state  <= ST_COMB;
                    end
                end
                ST_COMB: begin
                    r_comb_x             <= r_comb_x - r_dly[r_stage][DIFF_DELAY-1];
                    r_dly[r_stage][0]    <= r_comb_x;
                    for (int m = 1; m < DIFF_DELAY; m++) begin
                        r_dly[r_stage][m] <= r_dly[r_stage][m-1];
                    end
                    if (r_stage == LAST_STG) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_stage <= r_stage + STG_W'(1);
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CIC_ROUND_EN
    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH:0] HALF =
        (SHIFT > 0) ? (AW1'(1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : AW1'(0);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    function automatic logic [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] y);
        logic signed [ACC_WIDTH:0] sum;
        logic signed [ACC_WIDTH:0] q;
        sum = {y[ACC_WIDTH-1], y} + HALF;
        q   = sum >>> SHIFT;
        if (q > OUT_MAX) begin
            return OUT_MAX[OUT_WIDTH-1:0];
        end else if (q < OUT_MIN) begin
            return OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            return q[OUT_WIDTH-1:0];
        end
    endfunction

    assign w_out_next = round_sat(r_comb_x);
`else
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic                        w_unused;

    assign w_shifted  = r_comb_x >>> SHIFT;
    assign w_out_next = w_shifted[OUT_WIDTH-1:0];
    assign w_unused   = ^w_shifted;
`endif

    // Output holding register: a new sample always wins; an unaccepted old one raises overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (r_state == ST_OUT) begin
            o_out_data  <= w_out_next;
            o_out_valid <= 1'b1;
            o_overrun   <= o_out_valid && !i_out_ready;
        end else begin
            o_overrun <= 1'b0;
            if (o_out_valid && i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

endmodule
